// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock supervisor: pulses the PLL reset, waits for a qualified lock, then releases sys_rst_n.
// Optional `define PLL_LOCK_LOSS_CNT_EN adds a saturating 16-bit count of lock losses seen while running.
module pll_lock_supervisor #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 50000,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned RTY_W          = 2
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             retry_req,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             fail,
  output logic [2:0]       state,
  output logic [RTY_W-1:0] retry_cnt
`ifdef PLL_LOCK_LOSS_CNT_EN
  ,
  output logic [15:0]      lock_loss_cnt
`endif
);

  localparam logic [2:0] PLL_RST   = 3'd0;
  localparam logic [2:0] WAIT_LOCK = 3'd1;
  localparam logic [2:0] STABLE    = 3'd2;
  localparam logic [2:0] RUN       = 3'd3;
  localparam logic [2:0] FAIL      = 3'd4;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RETRY_LIMIT = RTY_W'(MAX_RETRY);

  logic             locked_meta;
  logic             locked_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0]       state_d;
  logic [RTY_W-1:0] retry_d;

  // pll_locked is asynchronous to refclk; two flops resolve metastability.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make locked_s take the old locked_meta, giving a true two-stage chain.
      locked_meta <= pll_locked;
      locked_s    <= locked_meta;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state;
    cnt_d   = '0;
    retry_d = retry_cnt;
    case (state)
      PLL_RST: begin
        if (cnt == RST_LAST) state_d = WAIT_LOCK;
        else                 cnt_d   = cnt + 1'b1;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          if (retry_cnt == RETRY_LIMIT) begin
            state_d = FAIL;
          end else begin
            state_d = PLL_RST;
            retry_d = retry_cnt + 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      STABLE: begin
        // A drop takes priority over promotion, even on the terminal cycle.
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          state_d = RUN;
          retry_d = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RUN: begin
        retry_d = '0;
        if (!locked_s) state_d = PLL_RST;
      end
      FAIL: begin
        if (retry_req) begin
          state_d = PLL_RST;
          retry_d = '0;
        end
      end
      default: begin
        state_d = PLL_RST;
        retry_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they move on the same edge as state.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state     <= PLL_RST;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      retry_cnt <= retry_d;
      pll_rst   <= (state_d == PLL_RST);
      sys_rst_n <= (state_d == RUN);
      fail      <= (state_d == FAIL);
    end
  end

`ifdef PLL_LOCK_LOSS_CNT_EN
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      lock_loss_cnt <= '0;
    end else if (state == RUN && state_d == PLL_RST && lock_loss_cnt != 16'hFFFF) begin
      lock_loss_cnt <= lock_loss_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Sits directly downstream of the 50 MHz-in / 5 MHz-out PLL wrapper; consumes its `locked` output and drives its `rst` input.
- Sequences PLL reset, waits for lock with timeout and bounded retries, and qualifies lock stability.
- Releases a system reset for downstream logic, and re-sequences on loss of lock.
- Runs on the free-running reference clock, so it operates while the PLL is unlocked.

Parameters:
- PLL_RST_CYCLES, 16, cycles `pll_rst` is held high per reset attempt (>=2)
- LOCK_TIMEOUT, 50000, cycles to wait for lock before retry (1 ms at 50 MHz)
- STABLE_CYCLES, 1024, cycles `locked` must stay high continuously before release
- MAX_RETRY, 3, retries allowed before FAIL
- CNT_W, 16, cycle-counter width; must hold max(LOCK_TIMEOUT, STABLE_CYCLES, PLL_RST_CYCLES)-1
- RTY_W, 2, `retry_cnt` width; must hold MAX_RETRY

Ports:
- refclk  in  1  50 MHz free-running reference clock (same net as PLL refclk)
- rst  in  1  asynchronous active-low reset
- pll_locked  in  1  PLL locked, asynchronous to refclk
- retry_req  in  1  single-cycle pulse; restarts sequencing from FAIL only
- pll_rst  out  1  active-high reset to PLL `rst`
- sys_rst_n  out  1  active-low system reset, refclk domain, registered
- fail  out  1  lock could not be achieved within MAX_RETRY retries
- state  out  3  current FSM state encoding
- retry_cnt  out  RTY_W  retries consumed in the current acquisition

Behaviour:
- Reset is asynchronous and active-low: assertion is immediate; registers release on the refclk edge.
- Reset values: pll_rst=1, sys_rst_n=0, fail=0, state=PLL_RST (0), retry_cnt=0, cycle counter=0, sync flops=0.
- `pll_locked` passes through a 2-FF synchronizer to give `locked_s`; this adds 2 cycles of latency.
- All outputs are registered and change on the same edge as `state`.
- State encodings: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4. Encodings 5-7 go to PLL_RST next cycle.
- PLL_RST:
  - pll_rst=1, sys_rst_n=0.
  - Counter runs 0..PLL_RST_CYCLES-1; at terminal count go to WAIT_LOCK with counter=0.
  - pll_rst is high for exactly PLL_RST_CYCLES cycles per entry.
- WAIT_LOCK:
  - pll_rst=0, sys_rst_n=0.
  - If locked_s=1, go to STABLE with counter=0.
  - Else at counter=LOCK_TIMEOUT-1:
    - if retry_cnt==MAX_RETRY, go to FAIL;
    - otherwise retry_cnt++ and go to PLL_RST.
  - Lock seen on the timeout cycle wins, i.e. go to STABLE.
- STABLE:
  - pll_rst=0, sys_rst_n=0.
  - If locked_s=0, go to WAIT_LOCK with counter=0 and no retry increment. This applies even on the terminal cycle: a drop beats promotion.
  - At counter=STABLE_CYCLES-1 with locked_s=1, go to RUN.
- RUN:
  - sys_rst_n=1, pll_rst=0, retry_cnt cleared on entry.
  - If locked_s=0, go to PLL_RST; sys_rst_n drops on the same edge.
  - Total latency from the `pll_locked` falling edge to sys_rst_n=0 is ≤3 refclk cycles.
- FAIL:
  - fail=1, pll_rst=0, sys_rst_n=0; the block holds here.
  - On retry_req=1, go to PLL_RST with retry_cnt=0 and fail=0 on the same edge.
  - retry_req is ignored in all other states.
- Counter widths: the counter never wraps; it is cleared on every state transition.
- A glitch on pll_locked shorter than one refclk period may be missed; this is acceptable.

Optional Feature:
- Macro: PLL_LOCK_LOSS_CNT_EN
- When defined:
  - Adds output `lock_loss_cnt`, out, 16 bits, reset to 0.
  - Increments on every RUN→PLL_RST transition.
  - Saturates at 16'hFFFF.
  - Is not cleared by retry_req.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
All tests use PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2.
- Reset then normal lock:
  - Release rst; raise pll_locked 10 cycles later.
  - pll_rst is high exactly 4 cycles, then low.
  - state goes 0→1→2→3; sys_rst_n rises 8 cycles after state=2 is entered.
  - fail=0 throughout.
- Lock timeout and retries:
  - Hold pll_locked=0.
  - Expect 3 PLL_RST pulses of 4 cycles each, separated by 20-cycle waits.
  - retry_cnt steps 0→1→2; state=4 and fail=1 after the third timeout.
  - retry_req pulse gives state=0, fail=0, retry_cnt=0.
- Stability glitch:
  - Drop pll_locked for 2 cycles at STABLE counter=5.
  - state returns to 1 with no pll_rst pulse and retry_cnt unchanged.
  - After relock, 8 clean cycles are needed before sys_rst_n=1.
- Loss of lock in RUN:
  - Drop pll_locked while state=3.
  - sys_rst_n=0 within 3 cycles; pll_rst high 4 cycles; full re-acquisition follows.
  - With PLL_LOCK_LOSS_CNT_EN, lock_loss_cnt=1.
- Async reset mid-operation:
  - Assert rst while in RUN and mid-cycle.
  - Outputs take their reset values immediately: sys_rst_n=0, pll_rst=1, state=0.
- Ignored retry_req:
  - Pulse retry_req in states 1, 2 and 3.
  - No state, counter or retry_cnt change.
